// File: rtl/vga_pkg.sv
// Shared fetch FSM state type and default line geometry, also used by the scanout/timing block.
package vga_pkg;

    typedef enum logic [2:0] {IDLE, REQ, BURST, DRAIN, DONE} fetch_state_t;

    localparam int          DEF_LINE_WORDS  = 160;
    localparam int          DEF_BURST_WORDS = 16;
    localparam logic [20:0] DEF_FB_BASE     = 21'h0;

    // Word address of a scanline; wraps modulo 2^21.
    function automatic logic [20:0] line_base(input logic [20:0] fb_base,
                                              input logic [9:0]  idx,
                                              input int          line_words);
        logic [31:0] prod;
        prod = {22'd0, idx} * line_words;
        return fb_base + prod[20:0];
    endfunction

endpackage

// File: rtl/vga_line_fetcher_if.sv
// VGA read port between the line fetcher (master) and the SDRAM controller (slave).
interface vga_line_fetcher_if;
    logic        vga_ren;
    logic [31:0] vga_addr;
    logic        vga_ack;
    logic [31:0] mem_data;

    modport master (output vga_ren, vga_addr, input vga_ack, mem_data);
    modport slave  (input vga_ren, vga_addr, output vga_ack, mem_data);
endinterface

// File: rtl/line_buffer_2bank.sv
// Two-bank scanline buffer: one write port, one registered read port; maps onto block RAM.
module line_buffer_2bank
    import vga_pkg::*;
#(
    parameter  int LINE_WORDS = DEF_LINE_WORDS,
    localparam int AW         = $clog2(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [2][LINE_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[wr_bank][wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[rd_bank][rd_idx];
    end

endmodule

// File: rtl/vga_line_fetcher.sv
// Per-scanline burst fetcher from SDRAM into a ping-pong line buffer.
// Optional watchdog: define VGA_FETCH_TIMEOUT_EN.
module vga_line_fetcher
    import vga_pkg::*;
#(
    parameter  int          LINE_WORDS     = DEF_LINE_WORDS,
    parameter  int          BURST_WORDS    = DEF_BURST_WORDS,
    parameter  logic [20:0] FB_BASE        = DEF_FB_BASE,
    parameter  int          TIMEOUT_CYCLES = 2047,
    localparam int          AW             = $clog2(LINE_WORDS)
) (
    input  logic                sdram_clk,
    input  logic                reset_n,
    input  logic                line_start,
    input  logic [9:0]          line_index,
    input  logic                swap,
    vga_line_fetcher_if.master  bus,
    input  logic [AW-1:0]       rd_addr,
    output logic [31:0]         rd_data,
    output logic                fetch_busy,
    output logic                fetch_done,
    output logic                overrun,
    output logic                timeout_err
);

    localparam int WCW = $clog2(LINE_WORDS + 1);
    localparam int BCW = $clog2(BURST_WORDS + 1);

    fetch_state_t   state;
    logic           ren;
    logic [20:0]    addr;
    logic [WCW-1:0] word_cnt;
    logic [BCW-1:0] beat_cnt;
    logic           wbank;
    logic           disp_bank;
    logic           we;
    logic           active;
    logic           to_hit;

    assign bus.vga_ren  = ren;
    assign bus.vga_addr = {11'd0, addr};
    assign active       = (state == REQ) || (state == BURST) || (state == DRAIN);
    assign we           = bus.vga_ack && ((state == REQ) || (state == BURST));

`ifdef VGA_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          ack_q;

    assign to_hit = active && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Any change on vga_ack counts as progress and restarts the watchdog.
    always_ff @(posedge sdram_clk) begin
        if (!reset_n) begin
            to_cnt      <= '0;
            ack_q       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack_q <= bus.vga_ack;
            if (!active || (bus.vga_ack != ack_q)) to_cnt <= '0;
            else                                   to_cnt <= to_cnt + 1'b1;
            if (to_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge sdram_clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ren        <= 1'b0;
            addr       <= '0;
            word_cnt   <= '0;
            beat_cnt   <= '0;
            wbank      <= 1'b0;
            disp_bank  <= 1'b0;
            fetch_busy <= 1'b0;
            fetch_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            if (swap) disp_bank <= ~disp_bank;
            if (fetch_busy && (swap || line_start)) overrun <= 1'b1;

            if (to_hit) begin
                ren        <= 1'b0;
                fetch_busy <= 1'b0;
                fetch_done <= 1'b1;
                state      <= DONE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        state <= IDLE;
                        if (line_start) begin
                            // A same-cycle swap counts first: target the post-swap write bank.
                            addr       <= line_base(FB_BASE, line_index, LINE_WORDS);
                            wbank      <= ~(disp_bank ^ swap);
                            word_cnt   <= '0;
                            beat_cnt   <= '0;
                            ren        <= 1'b1;
                            fetch_busy <= 1'b1;
                            state      <= REQ;
                        end
                    end
                    REQ: begin
                        if (bus.vga_ack) begin
                            ren      <= 1'b0;
                            word_cnt <= word_cnt + 1'b1;
                            beat_cnt <= BCW'(1);
                            state    <= (BURST_WORDS == 1) ? DRAIN : BURST;
                        end
                    end
                    BURST: begin
                        if (bus.vga_ack) begin
                            word_cnt <= word_cnt + 1'b1;
                            beat_cnt <= beat_cnt + 1'b1;
                            if (beat_cnt == BCW'(BURST_WORDS - 1)) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!bus.vga_ack) begin
                            if (word_cnt == WCW'(LINE_WORDS)) begin
                                fetch_busy <= 1'b0;
                                fetch_done <= 1'b1;
                                state      <= DONE;
                            end else begin
                                addr  <= addr + 21'(BURST_WORDS);
                                ren   <= 1'b1;
                                state <= REQ;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    line_buffer_2bank #(.LINE_WORDS(LINE_WORDS)) u_buf (
        .clk     (sdram_clk),
        .rst_n   (reset_n),
        .we      (we),
        .wr_bank (wbank),
        .wr_idx  (word_cnt[AW-1:0]),
        .wr_data (bus.mem_data),
        .rd_bank (disp_bank),
        .rd_idx  (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Scoreboard bench for vga_line_fetcher with a behavioural SDRAM read-port model.
module tb_vga_line_fetcher;
    import vga_pkg::*;

    localparam int LW = 160;
    localparam int BW = 16;
    localparam int NB = LW / BW;

    logic        sdram_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  line_index = '0;
    logic        swap = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        fetch_busy, fetch_done, overrun, timeout_err;

    vga_line_fetcher_if bus ();

    vga_line_fetcher dut (
        .sdram_clk   (sdram_clk),
        .reset_n     (reset_n),
        .line_start  (line_start),
        .line_index  (line_index),
        .swap        (swap),
        .bus         (bus),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .fetch_busy  (fetch_busy),
        .fetch_done  (fetch_done),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 sdram_clk = ~sdram_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_word_q[$];

    always @(posedge sdram_clk) if (fetch_done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [20:0] a);
        return {a[10:0], a} ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [20:0] base_of(input int idx);
        return 21'(idx * LW);
    endfunction

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic start_line(input int idx, input logic do_swap);
        line_index = 10'(idx);
        line_start = 1'b1;
        swap       = do_swap;
        for (int b = 0; b < NB; b++)
            exp_addr_q.push_back(32'(base_of(idx) + 21'(b * BW)));
        tick();
        line_start = 1'b0;
        swap       = 1'b0;
    endtask

    // Controller model: answers each request, optional long first-ack delay, one burst with a 17th ack.
    task automatic serve_line(input int delay0, input int extra_burst);
        for (int b = 0; b < NB; b++) begin
            int w;
            int nacks;
            logic [31:0] a;
            logic [31:0] ea;
            w = 0;
            while (!bus.vga_ren && w < 64) begin
                tick();
                w++;
            end
            if (!bus.vga_ren) begin
                chk("req_wait", 32'(bus.vga_ren), 32'd1);
                return;
            end
            ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
            chk("vga_addr", bus.vga_addr, ea);
            a = bus.vga_addr;
            for (int d = 0; d < ((b == 0) ? delay0 : (b % 3)); d++) tick();
            if (b == 0 && delay0 > 0) chk("ren_held", 32'(bus.vga_ren), 32'd1);
            nacks = (b == extra_burst) ? BW + 1 : BW;
            for (int k = 0; k < nacks; k++) begin
                if (b == 2 && k == 8) begin
                    bus.vga_ack = 1'b0;
                    tick();
                end
                bus.vga_ack = 1'b1;
                if (k < BW) begin
                    bus.mem_data = word_of(a[20:0] + 21'(k));
                    exp_word_q.push_back(bus.mem_data);
                end else begin
                    bus.mem_data = 32'hDEAD_BEEF;
                end
                tick();
                if (k == 0) chk("ren_drop", 32'(bus.vga_ren), 32'd0);
            end
            bus.vga_ack  = 1'b0;
            bus.mem_data = '0;
        end
    endtask

    task automatic finish_line(input int d0);
        tick();
        chk("fetch_done", 32'(fetch_done), 32'd1);
        chk("busy_drop", 32'(fetch_busy), 32'd0);
        tick();
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        repeat (4) tick();
        chk("no_extra_req", 32'(bus.vga_ren), 32'd0);
    endtask

    task automatic swap_and_read();
        swap = 1'b1;
        tick();
        swap = 1'b0;
        for (int i = 0; i < LW; i++) begin
            logic [31:0] e;
            rd_addr = 8'(i);
            tick();
            e = (exp_word_q.size() != 0) ? exp_word_q.pop_front() : 32'hFFFF_FFFF;
            chk("line_word", rd_data, e);
        end
        chk("word_q_empty", 32'(exp_word_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        bus.vga_ack  = 1'b0;
        bus.mem_data = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_ren", 32'(bus.vga_ren), 32'd0);
        chk("rst_addr", bus.vga_addr, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_done", 32'(fetch_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);

        // Line 2: plain fetch, bursts at 320..464, into bank 1.
        d0 = done_cnt;
        start_line(2, 1'b0);
        chk("ren_rise", 32'(bus.vga_ren), 32'd1);
        chk("busy_rise", 32'(fetch_busy), 32'd1);
        serve_line(0, -1);
        finish_line(d0);
        swap_and_read();

        // Line 3: first ack held off for a refresh window.
        d0 = done_cnt;
        start_line(3, 1'b0);
        serve_line(700, -1);
        finish_line(d0);
        swap_and_read();

        // Line 5: a 17th ack on burst 4 must be dropped.
        d0 = done_cnt;
        start_line(5, 1'b0);
        serve_line(0, 4);
        finish_line(d0);
        swap_and_read();

        // Line 9: a second line_start mid-fetch is refused and flagged.
        d0 = done_cnt;
        chk("overrun_pre", 32'(overrun), 32'd0);
        start_line(9, 1'b0);
        fork
            serve_line(0, -1);
            begin
                repeat (30) tick();
                line_index = 10'd100;
                line_start = 1'b1;
                tick();
                line_start = 1'b0;
            end
        join
        finish_line(d0);
        chk("overrun_set", 32'(overrun), 32'd1);
        swap_and_read();

        // disp_bank is 0 here; swap with line_start: display flips to bank 1, fetch fills bank 0.
        d0 = done_cnt;
        rd_addr = 8'd0;
        start_line(7, 1'b1);
        chk("read_old_bank", rd_data, word_of(base_of(9)));
        rd_addr = 8'd5;
        tick();
        chk("read_new_bank", rd_data, word_of(base_of(5) + 21'd5));
        chk("busy_swapstart", 32'(fetch_busy), 32'd1);
        serve_line(0, -1);
        finish_line(d0);
        swap_and_read();

        // Reset while requesting, then a stray ack in IDLE.
        start_line(1, 1'b0);
        exp_addr_q.delete();
        tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_ren", 32'(bus.vga_ren), 32'd0);
        chk("midrst_busy", 32'(fetch_busy), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        bus.vga_ack = 1'b1;
        repeat (3) tick();
        bus.vga_ack = 1'b0;
        chk("stray_ack_ren", 32'(bus.vga_ren), 32'd0);
        chk("stray_ack_busy", 32'(fetch_busy), 32'd0);

`ifdef VGA_FETCH_TIMEOUT_EN
        begin
            int w;
            start_line(11, 1'b0);
            exp_addr_q.delete();
            w = 0;
            while (!fetch_done && w < 2300) begin
                tick();
                w++;
            end
            chk("to_done", 32'(fetch_done), 32'd1);
            chk("to_err", 32'(timeout_err), 32'd1);
            chk("to_ren", 32'(bus.vga_ren), 32'd0);
            chk("to_min_wait", 32'(w >= 2000), 32'd1);
        end
`else
        chk("no_timeout", 32'(timeout_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_line_fetcher.md
# vga_line_fetcher

Initiator on the VGA read port of the SDRAM controller. Once per scanline it fetches one line of framebuffer words from SDRAM in fixed-length bursts and stores them in a ping-pong line buffer. The scanout logic reads that buffer at pixel rate. It drives `vga_ren`/`vga_addr` and consumes `vga_ack` plus the controller's `data_out`, all in the SDRAM clock domain.

## Interface
Parameters:
- `LINE_WORDS`, 160: 32-bit words per scanline; must be a multiple of `BURST_WORDS`.
- `BURST_WORDS`, 16: words returned per `vga_ren` request; fixed by the controller.
- `FB_BASE`, 21'h0: word address of line 0.
- `TIMEOUT_CYCLES`, 2047: watchdog limit, used only with the macro.

Ports:
- `sdram_clk`  in  1: sole clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `line_start`  in  1: one-cycle pulse requesting a fetch of `line_index`.
- `line_index`  in  10: scanline number, sampled with `line_start`.
- `swap`  in  1: one-cycle pulse at end of displayed line; exchanges buffer banks.
- `vga_ren`  out  1: read request to the controller.
- `vga_addr`  out  32: word address of the current burst; bits [31:21] are zero.
- `vga_ack`  in  1: controller word-valid strobe.
- `mem_data`  in  32: controller `data_out`.
- `rd_addr`  in  $clog2(LINE_WORDS): scanout read index into the display bank.
- `rd_data`  out  32: display-bank word, registered, 1-cycle latency.
- `fetch_busy`  out  1: high from accepted `line_start` until line complete.
- `fetch_done`  out  1: one-cycle pulse when the last word of the line is written.
- `overrun`  out  1: sticky flag.
- `timeout_err`  out  1: sticky flag; tied 0 without the macro.

## Operation
- States: IDLE, REQ, BURST, DRAIN, DONE.
- IDLE: on `line_start`, latch `base = FB_BASE + line_index*LINE_WORDS`. Result is 21-bit, wraps modulo 2^21. Clear `word_cnt` and `burst_cnt`, go to REQ.
- REQ: `vga_ren=1`, `vga_addr = base + burst_cnt*BURST_WORDS`. Held until the first cycle with `vga_ack=1`. That word is captured, then go to BURST.
- BURST: `vga_ren=0`. Every cycle with `vga_ack=1` writes `mem_data` to `wbank[word_cnt]` and increments `word_cnt`. After `BURST_WORDS` captures in this burst, go to DRAIN.
- DRAIN: wait for `vga_ack=0`. If `word_cnt==LINE_WORDS`, go to DONE. Otherwise increment `burst_cnt` and go to REQ.
- DONE: pulse `fetch_done`, go to IDLE.
- Captures beyond `BURST_WORDS` in DRAIN are discarded and never written.
- `line_start` while `fetch_busy`: ignored and `overrun` set. The fetch in progress continues unaffected.
- `swap`: toggles `disp_bank`; the write bank is always `~disp_bank`. If `swap` arrives while `fetch_busy`, `overrun` is set, the bank toggles anyway, and the fetch keeps writing the bank it started in. That bank is latched at `line_start`.
- `swap` and `line_start` in the same cycle: the swap is applied first, and the new fetch targets the new write bank.
- Flags clear only on reset.

## Timing
- Reset values: `vga_ren=0`, `vga_addr=0`, `rd_data=0`, `fetch_busy=0`, `fetch_done=0`, `overrun=0`, `timeout_err=0`, `disp_bank=0`, state IDLE. Buffer contents are undefined.
- `vga_ren` rises the cycle after `line_start`. `fetch_busy` rises in that same cycle.
- `vga_ren` falls the cycle after the first `vga_ack`. The controller samples requests only in its idle state, so holding `vga_ren` through controller refresh is required.
- `fetch_done` is asserted the cycle after DRAIN sees `vga_ack=0` on the final burst. `fetch_busy` drops in the same cycle.
- `rd_data` reflects `rd_addr` from the previous cycle. A bank toggle takes effect on reads issued the cycle after `swap`.
- Reset mid-burst: immediately returns to IDLE and deasserts `vga_ren`. Any stray `vga_ack` seen in IDLE is ignored.

## Configuration
- `VGA_FETCH_TIMEOUT_EN` defined:
  - A counter runs in REQ, BURST and DRAIN, cleared on each `vga_ack` edge.
  - Reaching `TIMEOUT_CYCLES` sets `timeout_err`, drops `vga_ren`, and goes to DONE with a `fetch_done` pulse.
  - The buffer remainder is stale.
- Undefined: no counter, `timeout_err` tied 0, and the block waits indefinitely.

## Structure
- Shared package `vga_pkg`: the `fetch_state_t` enum and the default `LINE_WORDS`/`BURST_WORDS`/`FB_BASE` constants, reused by the scanout/timing block.
- One sub-module, `line_buffer_2bank`: 2×`LINE_WORDS`×32 simple dual-port RAM with a write port (bank, index, data, we) and a registered read port. It infers block RAM.

## Test plan
- Reset then `line_start` with `line_index=2`, controller model acking 16 words per request -> 10 requests at `vga_addr` 320, 336, …, 464; `fetch_done` once; buffer holds 160 words in order.
- Controller model delays the first ack by 700 cycles (refresh) -> `vga_ren` held the whole time, no lost or duplicate words.
- Model returns 17 acks on one burst -> 17th word discarded, next request address still +16.
- `line_start` during a fetch -> `overrun=1`, the fetch completes normally with exactly 160 writes.
- `swap` plus `line_start` in the same cycle with `disp_bank=0` -> `disp_bank=1`, the fetch writes bank 0, and scanout reads bank 1 the next cycle.
- With `VGA_FETCH_TIMEOUT_EN`, model never acks -> `timeout_err=1` after 2047 cycles, `vga_ren=0`, `fetch_done` pulses.
